// File: rtl/mbi5153_line_tx_if.sv
// Bundle of the line transmitter's sequencer handshake, pixel RAM read port and MBI5153 pins.
interface mbi5153_line_tx_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  request;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  ready;
  logic                  busy;
  logic                  tx_done;
  logic                  ram_rd;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  sdi;
  logic                  le;
  logic                  dclk_en;

  modport master (
    output request, base_addr, ram_data,
    input  ready, busy, tx_done, ram_rd, ram_addr, sdi, le, dclk_en
  );

  modport slave (
    input  request, base_addr, ram_data,
    output ready, busy, tx_done, ram_rd, ram_addr, sdi, le, dclk_en
  );
endinterface

// File: rtl/mbi5153_line_tx.sv
// Fetches one line of grayscale words from pixel RAM in channel-major, farthest-IC-first order
// and shifts it gaplessly into the MBI5153 daisy chain with an LE pulse per channel.
module mbi5153_line_tx #(
  parameter int unsigned NUM_CH_IC    = 16,
  parameter int unsigned NUM_IC_CHAIN = 4,
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned DATA_WIDTH   = 16
) (
  input logic              i_clk,
  input logic              i_rst_n,
  mbi5153_line_tx_if.slave bus
);
  localparam int unsigned ChW  = (NUM_CH_IC > 1) ? $clog2(NUM_CH_IC) : 1;
  localparam int unsigned IcW  = (NUM_IC_CHAIN > 1) ? $clog2(NUM_IC_CHAIN) : 1;
  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [ChW-1:0]  LastCh   = ChW'(NUM_CH_IC - 1);
  localparam logic [IcW-1:0]  LastIc   = IcW'(NUM_IC_CHAIN - 1);
  localparam logic [CntW-1:0] FirstBit = CntW'(DATA_WIDTH - 1);
  localparam logic [CntW-1:0] HoldBit  = CntW'(DATA_WIDTH - 2);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StShift, StDone} state_e;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ChW-1:0]        r_ch;
  logic [IcW-1:0]        r_ic;
  logic [CntW-1:0]       r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shreg, r_hold;
  logic                  r_ready, r_busy, r_tx_done, r_ram_rd, r_le, r_dclk_en;
  logic [ADDR_WIDTH-1:0] r_ram_addr;

  state_e                w_state_d;
  logic [ADDR_WIDTH-1:0] w_base_d;
  logic [ChW-1:0]        w_ch_d, w_nxt_ch;
  logic [IcW-1:0]        w_ic_d, w_nxt_ic;
  logic [CntW-1:0]       w_bit_cnt_d;
  logic [DATA_WIDTH-1:0] w_shreg_d, w_hold_d;
  logic                  w_ready_d, w_busy_d, w_tx_done_d, w_ram_rd_d, w_le_d, w_dclk_en_d;
  logic [ADDR_WIDTH-1:0] w_ram_addr_d;

  function automatic logic [ADDR_WIDTH-1:0] offset(input logic [ChW-1:0] ch,
                                                   input logic [IcW-1:0] ic);
    return ADDR_WIDTH'(ic) * ADDR_WIDTH'(NUM_CH_IC) + ADDR_WIDTH'(ch);
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_base     <= '0;
      r_ch       <= '0;
      r_ic       <= LastIc;
      r_bit_cnt  <= FirstBit;
      r_shreg    <= '0;
      r_hold     <= '0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
      r_ram_rd   <= 1'b0;
      r_ram_addr <= '0;
      r_le       <= 1'b0;
      r_dclk_en  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_base     <= w_base_d;
      r_ch       <= w_ch_d;
      r_ic       <= w_ic_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_shreg    <= w_shreg_d;
      r_hold     <= w_hold_d;
      r_ready    <= w_ready_d;
      r_busy     <= w_busy_d;
      r_tx_done  <= w_tx_done_d;
      r_ram_rd   <= w_ram_rd_d;
      r_ram_addr <= w_ram_addr_d;
      r_le       <= w_le_d;
      r_dclk_en  <= w_dclk_en_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_base_d    = r_base;
    w_ch_d      = r_ch;
    w_ic_d      = r_ic;
    w_bit_cnt_d = r_bit_cnt;
    w_shreg_d   = r_shreg;
    w_hold_d    = r_hold;
    unique case (r_state)
      StIdle: begin
        if (bus.request) begin
          w_state_d   = StFetch;
          w_base_d    = bus.base_addr;
          w_ch_d      = '0;
          w_ic_d      = LastIc;
          w_bit_cnt_d = FirstBit;
        end
      end
      StFetch: w_state_d = StLoad;
      StLoad: begin
        w_state_d   = StShift;
        w_shreg_d   = bus.ram_data;
        w_bit_cnt_d = FirstBit;
      end
      StShift: begin
        w_shreg_d   = {r_shreg[DATA_WIDTH-2:0], 1'b0};
        w_bit_cnt_d = r_bit_cnt - CntW'(1);
        // Prefetched word arrives one cycle after its read strobe.
        if (r_bit_cnt == HoldBit) w_hold_d = bus.ram_data;
        if (r_bit_cnt == '0) begin
          if (r_ch == LastCh && r_ic == '0) begin
            w_state_d = StDone;
            w_shreg_d = '0;
          end else begin
            w_shreg_d   = r_hold;
            w_bit_cnt_d = FirstBit;
            if (r_ic == '0) begin
              w_ic_d = LastIc;
              w_ch_d = r_ch + ChW'(1);
            end else begin
              w_ic_d = r_ic - IcW'(1);
            end
          end
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are decoded from next-state values so every pin comes straight off a flop.
  always_comb begin
    w_ready_d    = (w_state_d == StIdle);
    w_busy_d     = (w_state_d == StFetch) || (w_state_d == StLoad) || (w_state_d == StShift);
    w_tx_done_d  = (w_state_d == StDone);
    w_dclk_en_d  = (w_state_d == StShift);
    w_le_d       = (w_state_d == StShift) && (w_bit_cnt_d == '0) && (w_ic_d == '0);
    w_nxt_ch     = (w_ic_d == '0) ? w_ch_d + ChW'(1) : w_ch_d;
    w_nxt_ic     = (w_ic_d == '0) ? LastIc : w_ic_d - IcW'(1);
    w_ram_rd_d   = 1'b0;
    w_ram_addr_d = r_ram_addr;
    if (r_state == StIdle && w_state_d == StFetch) begin
      w_ram_rd_d   = 1'b1;
      w_ram_addr_d = w_base_d + offset('0, LastIc);
    end else if (w_state_d == StShift && w_bit_cnt_d == FirstBit &&
                 !(w_ch_d == LastCh && w_ic_d == '0)) begin
      w_ram_rd_d   = 1'b1;
      w_ram_addr_d = w_base_d + offset(w_nxt_ch, w_nxt_ic);
    end
  end

  assign bus.ready    = r_ready;
  assign bus.busy     = r_busy;
  assign bus.tx_done  = r_tx_done;
  assign bus.ram_rd   = r_ram_rd;
  assign bus.ram_addr = r_ram_addr;
  assign bus.sdi      = r_shreg[DATA_WIDTH-1];
  assign bus.le       = r_le;
  assign bus.dclk_en  = r_dclk_en;
endmodule

// File: tb/tb_mbi5153_line_tx.sv
// Self-checking bench for mbi5153_line_tx: expected bit stream, LE and read addresses come from
// the channel/IC ordering rule applied to a behavioural pixel RAM.
module tb_mbi5153_line_tx;
  localparam int NCH = 16, NIC = 4, AW = 11, DW = 16;
  localparam int W = NCH * NIC, BITS = W * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mbi5153_line_tx_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mbi5153_line_tx #(
    .NUM_CH_IC(NCH), .NUM_IC_CHAIN(NIC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  logic [15:0] mem [0:2047];
  always @(posedge clk) if (bus.ram_rd) bus.ram_data <= mem[bus.ram_addr];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_addr(input int base, input int w);
    int ch = w / NIC;
    int ic = NIC - 1 - (w % NIC);
    return (base + ic * NCH + ch) % (1 << AW);
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, bus.ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_tx_done"}, bus.tx_done, 0);
    chk({tag, "_ram_rd"}, bus.ram_rd, 0);
    chk({tag, "_ram_addr"}, bus.ram_addr, 0);
    chk({tag, "_sdi"}, bus.sdi, 0);
    chk({tag, "_le"}, bus.le, 0);
    chk({tag, "_dclk_en"}, bus.dclk_en, 0);
  endtask

  task automatic run_line(input int base, input bit hold, input bit skip_req);
    int le_cnt, dclk_cnt, waited;
    if (!skip_req) begin
      waited = 0;
      while (bus.ready !== 1'b1 && waited < 2000) begin
        tick();
        waited++;
      end
      chk("ready_before_req", bus.ready, 1);
      bus.base_addr = AW'(base);
      bus.request   = 1'b1;
      tick();
      if (!hold) bus.request = 1'b0;
    end else begin
      tick();
    end
    chk("fetch_rd", bus.ram_rd, 1);
    chk("fetch_addr", bus.ram_addr, exp_addr(base, 0));
    chk("fetch_busy", bus.busy, 1);
    chk("fetch_ready", bus.ready, 0);
    tick();
    chk("load_dclk", bus.dclk_en, 0);
    le_cnt   = 0;
    dclk_cnt = 0;
    for (int i = 0; i < BITS; i++) begin
      int w = i / DW;
      int b = DW - 1 - (i % DW);
      bit rd_exp = (i % DW == 0) && (w < W - 1);
      tick();
      dclk_cnt += int'(bus.dclk_en);
      le_cnt   += int'(bus.le);
      chk("dclk_en", bus.dclk_en, 1);
      chk("sdi", bus.sdi, mem[exp_addr(base, w)][b]);
      chk("le", bus.le, (i % (DW * NIC) == DW * NIC - 1));
      chk("ram_rd", bus.ram_rd, rd_exp);
      if (rd_exp) chk("ram_addr", bus.ram_addr, exp_addr(base, w + 1));
    end
    chk("le_count", le_cnt, NCH);
    chk("dclk_count", dclk_cnt, BITS);
    tick();
    chk("done_tx_done", bus.tx_done, 1);
    chk("done_busy", bus.busy, 0);
    chk("done_ready", bus.ready, 0);
    chk("done_dclk", bus.dclk_en, 0);
    chk("done_sdi", bus.sdi, 0);
    chk("done_le", bus.le, 0);
    tick();
    chk("after_ready", bus.ready, 1);
    chk("after_tx_done", bus.tx_done, 0);
  endtask

  initial begin
    int base;
    bus.request   = 1'b0;
    bus.base_addr = '0;
    for (int a = 0; a < 2048; a++) mem[a] = 16'(a);
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Identity RAM, base 0: first address 48, stream 0x0030, 0x0020, ...
    run_line(0, 1'b0, 1'b0);
    // Wrapping base.
    run_line(2040, 1'b0, 1'b0);

    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < 2048; a++) mem[a] = 16'($urandom);
      base = int'($urandom_range(0, 2047));
      run_line(base, 1'b0, 1'b0);
    end

    for (int a = 0; a < 2048; a++) mem[a] = 16'hFFFF;
    run_line(int'($urandom_range(0, 2047)), 1'b0, 1'b0);
    for (int a = 0; a < 2048; a++) mem[a] = 16'h0000;
    run_line(int'($urandom_range(0, 2047)), 1'b0, 1'b0);

    // REQUEST held high: second line must start the cycle after READY rises.
    for (int a = 0; a < 2048; a++) mem[a] = 16'($urandom);
    base = int'($urandom_range(0, 2047));
    run_line(base, 1'b1, 1'b0);
    run_line(base, 1'b1, 1'b1);
    bus.request = 1'b0;
    tick();
    chk("b2b_stop_busy", bus.busy, 0);
    chk("b2b_stop_ready", bus.ready, 1);

    // Reset in the middle of a line.
    for (int a = 0; a < 2048; a++) mem[a] = 16'(a);
    bus.base_addr = '0;
    bus.request   = 1'b1;
    tick();
    bus.request = 1'b0;
    for (int c = 0; c < 502; c++) tick();
    chk("midline_dclk", bus.dclk_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("reset_no_tx_done", bus.tx_done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset_ready", bus.ready, 1);
    run_line(0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
